serial_add_unit: RTL and testbench

SERIAL_ADD_UNIT -- requirements
Module: serial_add_unit

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_unit_fa.sv | 13 +
 rtl/serial_add_unit.sv | 124 ++++++++++++
 tb/tb_serial_add_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_unit_fa.sv
// Single-bit full adder used as the bit-slice of the serial adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder, LSB first, one bit per cycle through a single full adder.
// Optional subtract mode via SERIAL_ADD_SUB_EN (adds input port sub).
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_add_unit: WIDTH out of range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    always_comb begin
        b_eff = b;
        c_eff = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_eff = ~b;
            c_eff = 1'b1;
        end
`endif
    end

    fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (bit_s),
        .cout (bit_c)
    );

    // Result bits enter at the MSB and shift down, so after WIDTH cycles bit 0 is the LSB.
    always_comb begin
        acc_nxt            = acc >> 1;
        acc_nxt[WIDTH-1]   = bit_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_eff;
                        carry <= c_eff;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_c;
                    acc   <= acc_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry holds the carry into the MSB during the last slice
                        sum      <= acc_nxt;
                        cout     <= bit_c;
                        overflow <= carry ^ bit_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_unit;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start1, cin1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1, ovf1;

`ifdef SERIAL_ADD_SUB_EN
    logic sub, sub1;
`endif

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_add_unit #(.WIDTH(W)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (ovf)
    );

    serial_add_unit #(.WIDTH(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .a        (a1),
        .b        (b1),
        .cin      (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub1),
`endif
        .busy     (busy1),
        .done     (done1),
        .sum      (sum1),
        .cout     (cout1),
        .overflow (ovf1)
    );

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, input logic sb_);
        logic [7:0] yy;
        logic       c0;
        logic [8:0] t;
        res_t       r;
        yy  = sb_ ? ~y : y;
        c0  = sb_ ? 1'b1 : ci;
        t   = {1'b0, x} + {1'b0, yy} + {8'b0, c0};
        r.s = t[7:0];
        r.c = t[8];
        r.v = (x[7] == yy[7]) && (t[7] != x[7]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge while the DUT is idle; returns in cycle N+1.
    task automatic issue(input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic sb_);
        a   = x;
        b   = y;
        cin = ci;
`ifdef SERIAL_ADD_SUB_EN
        sub = sb_;
`endif
        start = 1'b1;
        sb.push_back(model(x, y, ci, sb_));
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int at, output int busy_n);
        at     = -1;
        busy_n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (busy) busy_n++;
            if (done) begin
                at = k;
                break;
            end
            step();
        end
    endtask

    task automatic pop_expected(output res_t e);
        if (sb.size() == 0) begin
            e = '0;
            n_fail++;
            $display("FAIL scoreboard_empty");
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        step();
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
        n_checks++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", cout, ovf); end
        n_checks++; if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin n_fail++; $display("FAIL reset_w1 got=%b%b%b%b%b exp=00000", busy1, done1, sum1, cout1, ovf1); end
        rst = 1'b0;
        start = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int   at, bn;
        res_t e;
        issue(8'h3C, 8'h55, 1'b0, 1'b0);
        wait_done(at, bn);
        pop_expected(e);
        n_checks++; if (at != 9) begin n_fail++; $display("FAIL basic_done_cycle got=%0d exp=9", at); end
        n_checks++; if (sum !== e.s) begin n_fail++; $display("FAIL basic_sum got=%h exp=%h", sum, e.s); end
        n_checks++; if (sum !== 8'h91) begin n_fail++; $display("FAIL basic_sum_const got=%h exp=91", sum); end
        n_checks++; if ({cout, ovf} !== {e.c, e.v}) begin n_fail++; $display("FAIL basic_flags got=%b%b exp=%b%b", cout, ovf, e.c, e.v); end
        step();
    endtask

    task automatic test_carry();
        int   at, bn;
        res_t e;
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        n_checks++; if (sum !== 8'h91) begin n_fail++; $display("FAIL carry_sum_hold got=%h exp=91", sum); end
        wait_done(at, bn);
        pop_expected(e);
        n_checks++; if (bn != 8) begin n_fail++; $display("FAIL carry_busy_cycles got=%0d exp=8", bn); end
        n_checks++; if (at != 9) begin n_fail++; $display("FAIL carry_done_cycle got=%0d exp=9", at); end
        n_checks++; if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin n_fail++; $display("FAIL carry_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf, e.s, e.c, e.v); end
        n_checks++; if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL carry_result_const got=%h/%b/%b exp=00/1/0", sum, cout, ovf); end
        step();
    endtask

    task automatic test_ignore_start();
        int   first, cnt;
        res_t e;
        first = -1;
        cnt   = 0;
        issue(8'h5A, 8'h33, 1'b1, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            if (done) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 3) begin
                start = 1'b1;
                a = 8'hA5; b = 8'h00; cin = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (first == k) begin
                pop_expected(e);
                n_checks++; if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin n_fail++; $display("FAIL ignore_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf, e.s, e.c, e.v); end
            end
            step();
        end
        n_checks++; if (first != 9) begin n_fail++; $display("FAIL ignore_done_cycle got=%0d exp=9", first); end
        n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", cnt); end
    endtask

    task automatic test_mid_reset();
        int   at, bn, seen;
        res_t e;
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        n_checks++; if ({busy, done, sum, cout, ovf} !== 12'h000) begin n_fail++; $display("FAIL abort_cleared got=%b%b/%h/%b%b exp=00/00/00", busy, done, sum, cout, ovf); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) seen++;
            step();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_activity got=%0d exp=0", seen); end
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(at, bn);
        pop_expected(e);
        n_checks++; if (at != 9) begin n_fail++; $display("FAIL abort_restart_cycle got=%0d exp=9", at); end
        n_checks++; if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin n_fail++; $display("FAIL abort_restart_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf, e.s, e.c, e.v); end
        step();
    endtask

    task automatic test_back_to_back();
        int   at, bn;
        res_t e;
        logic [7:0] xs[3] = '{8'h80, 8'h01, 8'hC3};
        logic [7:0] ys[3] = '{8'h80, 8'h7F, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            issue(xs[i], ys[i], i[0], 1'b0);
            wait_done(at, bn);
            pop_expected(e);
            n_checks++; if (at != 9) begin n_fail++; $display("FAIL b2b_done_cycle[%0d] got=%0d exp=9", i, at); end
            n_checks++; if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin n_fail++; $display("FAIL b2b_result[%0d] got=%h/%b/%b exp=%h/%b/%b", i, sum, cout, ovf, e.s, e.c, e.v); end
            step();
        end
    endtask

    task automatic test_random();
        int   at, bn;
        res_t e;
        logic sb_;
        for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            sb_ = 1'($urandom_range(0, 1));
`else
            sb_ = 1'b0;
`endif
            issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sb_);
            wait_done(at, bn);
            pop_expected(e);
            n_checks++; if (bn != 8 || at != 9) begin n_fail++; $display("FAIL rand_timing[%0d] got=%0d/%0d exp=8/9", i, bn, at); end
            n_checks++; if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin n_fail++; $display("FAIL rand_result[%0d] got=%h/%b/%b exp=%h/%b/%b", i, sum, cout, ovf, e.s, e.c, e.v); end
            step();
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int   at, bn;
        res_t e;
        issue(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(at, bn);
        pop_expected(e);
        n_checks++; if ({sum, cout, ovf} !== {8'hF0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub_neg got=%h/%b/%b exp=f0/0/0", sum, cout, ovf); end
        step();
        issue(8'h20, 8'h10, 1'b0, 1'b1);
        wait_done(at, bn);
        pop_expected(e);
        n_checks++; if ({sum, cout} !== {8'h10, 1'b1}) begin n_fail++; $display("FAIL sub_pos got=%h/%b exp=10/1", sum, cout); end
        n_checks++; if (ovf !== e.v) begin n_fail++; $display("FAIL sub_pos_ovf got=%b exp=%b", ovf, e.v); end
        step();
        sub = 1'b0;
    endtask
`endif

    task automatic test_width1();
        logic [1:0] t;
        logic       xa, xb, xc;
        for (int i = 0; i < 8; i++) begin
            xa = 1'(i >> 2);
            xb = 1'(i >> 1);
            xc = 1'(i);
            t  = {1'b0, xa} + {1'b0, xb} + {1'b0, xc};
            a1 = xa; b1 = xb; cin1 = xc;
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            n_checks++; if ({busy1, done1} !== 2'b10) begin n_fail++; $display("FAIL w1_run[%0d] got=%b%b exp=10", i, busy1, done1); end
            step();
            n_checks++; if ({busy1, done1} !== 2'b01) begin n_fail++; $display("FAIL w1_done[%0d] got=%b%b exp=01", i, busy1, done1); end
            n_checks++; if ({sum1, cout1, ovf1} !== {t[0], t[1], xc ^ t[1]}) begin n_fail++; $display("FAIL w1_result[%0d] got=%b%b%b exp=%b%b%b", i, sum1, cout1, ovf1, t[0], t[1], xc ^ t[1]); end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
